// File: rtl/me_pkg.sv
// me_pkg: shared widths, result constants and FSM encoding for the ME search sequencer.
package me_pkg;
    localparam int POS_W = 12;
    localparam int SAD_W = 16;
    localparam int DIFF_W = 4;
    localparam logic [SAD_W-1:0] SAD_MAX = 16'hFFFF;
    localparam logic [DIFF_W-1:0] DIFF_ERR = 4'hF;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, FIN} state_t;
endpackage

// File: rtl/me_grid_pos_gen.sv
// me_grid_pos_gen: raster i/j counters over the candidate grid.
// Produces origin + (i,j)*STEP with each 6-bit field wrapping mod 64.
module me_grid_pos_gen
    import me_pkg::*;
#(
    parameter int NUM_X = 4,
    parameter int NUM_Y = 4,
    parameter int STEP  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [POS_W-1:0] origin,
    output logic [POS_W-1:0] init_pos,
    output logic             last
);
    localparam logic [5:0] ST = 6'(STEP);
    logic [POS_W-1:0] org;
    logic [3:0] i, j;
    logic last_col;
    assign last_col = i == 4'(NUM_X - 1);
    assign last = last_col && j == 4'(NUM_Y - 1);
    // 6-bit arithmetic gives the mod-64 wrap for free
    assign init_pos = {org[11:6] + 6'(j) * ST, org[5:0] + 6'(i) * ST};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            org <= '0;
            i <= '0;
            j <= '0;
        end else if (clr) begin
            org <= origin;
            i <= '0;
            j <= '0;
        end else if (adv) begin
            i <= last_col ? 4'd0 : i + 4'd1;
            j <= last_col ? j + 4'd1 : j;
        end
endmodule

// File: rtl/me_search_sequencer.sv
// me_search_sequencer: sweeps a grid of ME start positions over req/ack, streams results, tracks the best.
// Define ME_SEQ_TIMEOUT_EN to add an ack watchdog (TIMEOUT_CYC) and a sticky err output.
module me_search_sequencer
    import me_pkg::*;
#(
    parameter int NUM_X = 4,
    parameter int NUM_Y = 4,
    parameter int STEP  = 16
`ifdef ME_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [POS_W-1:0]  origin,
    output logic              busy,
    output logic              done,
    output logic              req,
    output logic [POS_W-1:0]  init_pos,
    input  logic              ack,
    input  logic [SAD_W-1:0]  min_sad,
    input  logic [DIFF_W-1:0] min_diff,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [POS_W-1:0]  res_pos,
    output logic [SAD_W-1:0]  res_sad,
    output logic [DIFF_W-1:0] res_diff,
    output logic [POS_W-1:0]  best_pos,
    output logic [SAD_W-1:0]  best_sad,
    output logic [DIFF_W-1:0] best_diff
`ifdef ME_SEQ_TIMEOUT_EN
    ,
    output logic              err
`endif
);
    state_t state, state_nx;
    logic launch, cap, hs, last, to;
    assign launch = state == IDLE && start;
    assign cap = state == ISSUE && req && ack;
    assign hs = res_valid && res_ready;

    me_grid_pos_gen #(.NUM_X(NUM_X), .NUM_Y(NUM_Y), .STEP(STEP)) u_grid (
        .clk(clk),
        .rst_n(rst_n),
        .clr(launch),
        .adv(hs && !last),
        .origin(origin),
        .init_pos(init_pos),
        .last(last)
    );

`ifdef ME_SEQ_TIMEOUT_EN
    logic [15:0] wd;
    assign to = req && !ack && wd == 16'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wd <= '0;
            err <= 1'b0;
        end else begin
            wd <= req && !ack ? wd + 16'd1 : '0;
            err <= launch ? 1'b0 : err | to;
        end
`else
    assign to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE:   state_nx = cap ? EMIT : to ? WAIT : ISSUE;
            WAIT:    state_nx = ack ? WAIT : EMIT;
            EMIT:    state_nx = !res_ready ? EMIT : last ? FIN : ISSUE;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state == ISSUE || state == WAIT || state == EMIT;
        done = state == FIN;
        res_valid = state == EMIT;
    end

    // req only rises while ack is low, so a stale ack from the last run is never taken as completion
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            req <= 1'b0;
            res_pos <= '0;
            res_sad <= '0;
            res_diff <= '0;
            best_pos <= '0;
            best_sad <= SAD_MAX;
            best_diff <= '0;
        end else begin
            req <= state == ISSUE && !cap && !to && (req || !ack);
            if (cap) begin
                res_pos <= init_pos;
                res_sad <= min_sad;
                res_diff <= min_diff;
            end else if (to) begin
                res_pos <= init_pos;
                res_sad <= SAD_MAX;
                res_diff <= DIFF_ERR;
            end
            if (launch) begin
                best_sad <= SAD_MAX;
            end else if (cap && min_sad < best_sad) begin
                best_pos <= init_pos;
                best_sad <= min_sad;
                best_diff <= min_diff;
            end
        end
endmodule

// File: tb/tb_me_search_sequencer.sv
// tb_me_search_sequencer: scoreboard bench, 2x2 grid with a STEP 16 DUT and a STEP 8 twin on shared inputs.
module tb_me_search_sequencer;
    localparam int NX = 2;
    localparam int NY = 2;
    typedef struct packed {logic [11:0] pos; logic [15:0] sad; logic [3:0] diff;} res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [11:0] origin = '0;
    logic ack = 1'b0;
    logic [15:0] min_sad = '0;
    logic [3:0] min_diff = '0;
    logic res_ready = 1'b1;
    logic busy, done, req, res_valid;
    logic [11:0] init_pos, res_pos, best_pos;
    logic [15:0] res_sad, best_sad;
    logic [3:0] res_diff, best_diff;
    logic w_busy, w_done, w_req, w_res_valid;
    logic [11:0] w_init_pos, w_res_pos, w_best_pos;
    logic [15:0] w_res_sad, w_best_sad;
    logic [3:0] w_res_diff, w_best_diff;
`ifdef ME_SEQ_TIMEOUT_EN
    logic err, w_err;
`endif

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    me_search_sequencer #(.NUM_X(NX), .NUM_Y(NY), .STEP(16)
`ifdef ME_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC(20)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .origin(origin), .busy(busy), .done(done),
        .req(req), .init_pos(init_pos), .ack(ack), .min_sad(min_sad), .min_diff(min_diff),
        .res_valid(res_valid), .res_ready(res_ready), .res_pos(res_pos), .res_sad(res_sad),
        .res_diff(res_diff), .best_pos(best_pos), .best_sad(best_sad), .best_diff(best_diff)
`ifdef ME_SEQ_TIMEOUT_EN
        , .err(err)
`endif
    );

    me_search_sequencer #(.NUM_X(NX), .NUM_Y(NY), .STEP(8)
`ifdef ME_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC(20)
`endif
    ) twin (
        .clk(clk), .rst_n(rst_n), .start(start), .origin(origin), .busy(w_busy), .done(w_done),
        .req(w_req), .init_pos(w_init_pos), .ack(ack), .min_sad(min_sad), .min_diff(min_diff),
        .res_valid(w_res_valid), .res_ready(res_ready), .res_pos(w_res_pos), .res_sad(w_res_sad),
        .res_diff(w_res_diff), .best_pos(w_best_pos), .best_sad(w_best_sad), .best_diff(w_best_diff)
`ifdef ME_SEQ_TIMEOUT_EN
        , .err(w_err)
`endif
    );

    // ME core model: acks lat cycles after req, optionally holds ack, optionally never acks one index
    logic [15:0] sad_tab [4];
    int lat = 5, hold = 0, never_idx = -1, idx = 0, cnt = 0, hold_left = 0, to_len = 0;
    logic [11:0] pos_q [$];
    initial begin : me_model
        logic [11:0] p;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ack = 1'b0;
                cnt = 0;
                hold_left = 0;
            end else if (ack) begin
                if (!req) begin
                    if (hold_left > 0) hold_left--;
                    else ack = 1'b0;
                end
            end else if (req) begin
                cnt++;
                if (idx != never_idx && cnt >= lat) begin
                    ack = 1'b1;
                    min_sad = sad_tab[idx % 4];
                    min_diff = 4'(idx);
                    hold_left = hold;
                    cnt = 0;
                    checks++;
                    p = pos_q.size() != 0 ? pos_q.pop_front() : 12'hxxx;
                    if (init_pos !== p) begin
                        errs++;
                        $display("FAIL init_pos got %h required %h", init_pos, p);
                    end
                    idx++;
                end
            end else if (cnt > 0) begin
                to_len = cnt;
                cnt = 0;
                checks++;
                p = pos_q.size() != 0 ? pos_q.pop_front() : 12'hxxx;
                if (init_pos !== p) begin
                    errs++;
                    $display("FAIL timeout_pos got %h required %h", init_pos, p);
                end
                idx++;
            end
        end
    end

    res_t exp_q [$];
    logic [11:0] exp1_q [$];
    int n_hs = 0, n_done = 0, hs_cyc = 0;
    res_t e;
    logic [11:0] p1;
    always @(negedge clk) if (rst_n) begin
        if (res_valid && res_ready) begin
            n_hs++;
            hs_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL result_extra got pos=%h sad=%0d diff=%h", res_pos, res_sad, res_diff);
            end else begin
                e = exp_q.pop_front();
                if ({res_pos, res_sad, res_diff} !== e) begin
                    errs++;
                    $display("FAIL result got pos=%h sad=%0d diff=%h required pos=%h sad=%0d diff=%h",
                             res_pos, res_sad, res_diff, e.pos, e.sad, e.diff);
                end
            end
            if (exp1_q.size() != 0) begin
                checks++;
                p1 = exp1_q.pop_front();
                if (w_res_pos !== p1) begin
                    errs++;
                    $display("FAIL twin_pos got %h required %h", w_res_pos, p1);
                end
            end
        end
        if (done) begin
            n_done++;
            checks++;
            if (cyc != hs_cyc + 1) begin
                errs++;
                $display("FAIL done_latency got %0d cycles after handshake required 1", cyc - hs_cyc);
            end
        end
    end

    task automatic plan(input logic [11:0] org, input int skip);
        logic [5:0] y, x;
        res_t r;
        for (int k = 0; k < NX * NY; k++) begin
            y = org[11:6] + 6'(16 * (k / NX));
            x = org[5:0] + 6'(16 * (k % NX));
            pos_q.push_back({y, x});
            r = {y, x, k == skip ? 16'hFFFF : sad_tab[k], k == skip ? 4'hF : 4'(k)};
            exp_q.push_back(r);
        end
        idx = 0;
    endtask

    task automatic go(input logic [11:0] org);
        @(negedge clk);
        origin = org;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errs++;
            $display("FAIL %s_done got done=%b required 1 within 2000 cycles", tag, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, req, res_valid} !== 4'b0) begin
            errs++;
            $display("FAIL reset_ctl got %b required 0000", {busy, done, req, res_valid});
        end
        checks++;
        if (best_sad !== 16'hFFFF) begin
            errs++;
            $display("FAIL reset_best_sad got %h required ffff", best_sad);
        end
        checks++;
        if ({init_pos, res_pos, res_sad, res_diff, best_pos, best_diff} !== '0) begin
            errs++;
            $display("FAIL reset_data got %h required 0", {init_pos, res_pos, res_sad, res_diff, best_pos, best_diff});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int h0 = n_hs, d0 = n_done;
        sad_tab = '{16'd100, 16'd50, 16'd50, 16'd70};
        plan(12'h000, -1);
        go(12'h000);
        checks++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL basic_busy got %b required 1", busy);
        end
        wait_done("basic");
        checks++;
        if (n_hs - h0 != 4 || n_done - d0 != 1) begin
            errs++;
            $display("FAIL basic_counts got hs=%0d done=%0d required 4 1", n_hs - h0, n_done - d0);
        end
        checks++;
        if ({best_pos, best_sad, best_diff} !== {12'h010, 16'd50, 4'd1}) begin
            errs++;
            $display("FAIL basic_best got pos=%h sad=%0d diff=%h required 010 50 1", best_pos, best_sad, best_diff);
        end
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL basic_idle_busy got %b required 0", busy);
        end
    endtask

    task automatic test_wrap;
        sad_tab = '{16'd30, 16'd20, 16'd10, 16'd40};
        plan({6'd56, 6'd60}, -1);
        exp1_q = '{{6'd56, 6'd60}, {6'd56, 6'd4}, {6'd0, 6'd60}, {6'd0, 6'd4}};
        go({6'd56, 6'd60});
        wait_done("wrap");
        repeat (5) @(negedge clk);
        checks++;
        if ({best_pos, best_sad, best_diff} !== {6'd8, 6'd60, 16'd10, 4'd2}) begin
            errs++;
            $display("FAIL wrap_best got pos=%h sad=%0d diff=%h required 23c 10 2", best_pos, best_sad, best_diff);
        end
        checks++;
        if (w_best_pos !== {6'd0, 6'd60}) begin
            errs++;
            $display("FAIL wrap_twin_best got %h required 03c", w_best_pos);
        end
    endtask

    task automatic test_stall;
        int n = 0, bad = 0;
        logic [31:0] snap;
        logic [11:0] ip;
        sad_tab = '{16'd7, 16'd8, 16'd9, 16'd10};
        plan(12'h041, -1);
        res_ready = 1'b0;
        go(12'h041);
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!res_valid) begin
            errs++;
            $display("FAIL stall_valid got res_valid=%b required 1", res_valid);
        end
        snap = {res_pos, res_sad, res_diff};
        ip = init_pos;
        origin = 12'hFFF;
        start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
            if ({res_pos, res_sad, res_diff} !== snap || !res_valid || req || init_pos !== ip) bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL stall_hold got %0d unstable cycles required 0", bad);
        end
        res_ready = 1'b1;
        wait_done("stall");
        checks++;
        if ({best_pos, best_sad, best_diff} !== {12'h041, 16'd7, 4'd0}) begin
            errs++;
            $display("FAIL stall_best got pos=%h sad=%0d diff=%h required 041 7 0", best_pos, best_sad, best_diff);
        end
    endtask

    task automatic test_ack_hold;
        int n = 0, viol = 0, h0 = n_hs;
        logic prev_req = 1'b0, prev_ack = 1'b0;
        hold = 3;
        sad_tab = '{16'd5, 16'd6, 16'd7, 16'd8};
        plan(12'h000, -1);
        go(12'h000);
        while (!done && n < 2000) begin
            @(negedge clk);
            if (req && !prev_req && prev_ack) viol++;
            prev_req = req;
            prev_ack = ack;
            n++;
        end
        checks++;
        if (viol != 0 || !done) begin
            errs++;
            $display("FAIL hold_req got %0d reqs under ack, done=%b required 0 1", viol, done);
        end
        @(negedge clk);
        checks++;
        if (n_hs - h0 != 4 || idx != 4) begin
            errs++;
            $display("FAIL hold_count got hs=%0d acks=%0d required 4 4", n_hs - h0, idx);
        end
        hold = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n = 0, h0 = n_hs, d0;
        sad_tab = '{16'd100, 16'd50, 16'd50, 16'd70};
        plan(12'h000, -1);
        go(12'h000);
        while (!(n_hs - h0 == 1 && req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        d0 = n_done;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req, busy, res_valid} !== 3'b0 || best_sad !== 16'hFFFF) begin
            errs++;
            $display("FAIL mid_reset got req/busy/valid=%b best_sad=%h required 000 ffff", {req, busy, res_valid}, best_sad);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pos_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (n_done != d0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset_idle got done_pulses=%0d busy=%b required 0 0", n_done - d0, busy);
        end
        h0 = n_hs;
        plan(12'h000, -1);
        go(12'h000);
        wait_done("restart");
        checks++;
        if (n_hs - h0 != 4 || {best_pos, best_sad} !== {12'h010, 16'd50}) begin
            errs++;
            $display("FAIL restart got hs=%0d best=%h/%0d required 4 010/50", n_hs - h0, best_pos, best_sad);
        end
    endtask

`ifdef ME_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int h0 = n_hs;
        sad_tab = '{16'd40, 16'd10, 16'd30, 16'd20};
        never_idx = 1;
        plan(12'h000, 1);
        go(12'h000);
        wait_done("timeout");
        checks++;
        if (to_len != 20 || err !== 1'b1) begin
            errs++;
            $display("FAIL timeout got req_cycles=%0d err=%b required 20 1", to_len, err);
        end
        checks++;
        if (n_hs - h0 != 4 || {best_pos, best_sad, best_diff} !== {12'h410, 16'd20, 4'd3}) begin
            errs++;
            $display("FAIL timeout_best got hs=%0d pos=%h sad=%0d required 4 410 20", n_hs - h0, best_pos, best_sad);
        end
        never_idx = -1;
        plan(12'h000, -1);
        go(12'h000);
        checks++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL err_clear got %b required 0", err);
        end
        wait_done("after_timeout");
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_stall;
        test_ack_hold;
        test_reset_mid;
`ifdef ME_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || pos_q.size() != 0) begin
            errs++;
            $display("FAIL leftover got results=%0d positions=%0d required 0 0", exp_q.size(), pos_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
